scr_base_l3_bk_req_tx: RTL and testbench

Credit-based request transmitter that sits directly upstream of the L3 bank request queue. It drives that queue's req_in_val/req_in_flit inputs and consumes its req_in_crdt returns. Flits arrive from the L3 request crossbar over valid/ready and are buffered in a small skid FIFO. A flit is launched only when a downstream credit is held. The block owns the credit counter, which mirrors the free entries in the bank request queue.

---
 rtl/scr_base_l3_bk_req_tx_pkg.sv | 16 +
 rtl/scr_base_l3_bk_req_tx_if.sv | 27 ++
 rtl/scr_base_l3_bk_req_tx_sync_fifo.sv | 48 ++++
 rtl/scr_base_l3_bk_req_tx.sv | 156 +++++++++++++++
 tb/tb_scr_base_l3_bk_req_tx.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scr_base_l3_bk_req_tx_pkg.sv
// Shared types and constants for the L3 bank request transmitter.
package scr_base_l3_bk_pkg;

    localparam int SCR_L3_BK_FLIT_W       = 128;
    localparam int SCR_L3_BK_REQ_CRDT_MAX = 4;
    localparam int SCR_L3_BK_CRDT_W       = 4;

    typedef logic [SCR_L3_BK_FLIT_W-1:0] scr_l3_bk_flit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } scr_l3_bk_tx_state_e;

endpackage

// File: rtl/scr_base_l3_bk_req_tx_if.sv
// Upstream valid/ready, downstream credit/launch and status signals of the request transmitter.
interface scr_base_l3_bk_req_tx_if
    import scr_base_l3_bk_pkg::*;
#(
    parameter int FLIT_W = SCR_L3_BK_FLIT_W
);
    logic                        req_val_i;
    logic [FLIT_W-1:0]           req_flit_i;
    logic                        req_rdy_o;
    logic                        req_out_val_o;
    logic [FLIT_W-1:0]           req_out_flit_o;
    logic                        req_out_crdt_i;
    logic [SCR_L3_BK_CRDT_W-1:0] crdt_cnt_o;
    logic                        idle_o;
    logic                        crdt_err_o;

    modport master (
        output req_val_i, req_flit_i, req_out_crdt_i,
        input  req_rdy_o, req_out_val_o, req_out_flit_o, crdt_cnt_o, idle_o, crdt_err_o
    );

    modport slave (
        input  req_val_i, req_flit_i, req_out_crdt_i,
        output req_rdy_o, req_out_val_o, req_out_flit_o, crdt_cnt_o, idle_o, crdt_err_o
    );

endinterface

// File: rtl/scr_base_l3_bk_req_tx_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty come from the MSB compare.
module scr_base_l3_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count = r_wptr - r_rptr;
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/scr_base_l3_bk_req_tx.sv
// Credit-based request transmitter feeding the L3 bank request queue.
// Optional credit-overflow checking is enabled by defining SCR_L3_BK_REQ_TX_CRDT_CHK_EN.
module scr_base_l3_bk_req_tx
    import scr_base_l3_bk_pkg::*;
#(
    parameter int FLIT_W     = SCR_L3_BK_FLIT_W,
    parameter int CRDT_MAX   = SCR_L3_BK_REQ_CRDT_MAX,
    parameter int SKID_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    scr_base_l3_bk_req_tx_if.slave  bus
);
    localparam int                 AW          = $clog2(SKID_DEPTH);
    localparam int                 CW          = SCR_L3_BK_CRDT_W;
    localparam logic [CW-1:0]      LP_CRDT_MAX = CW'(CRDT_MAX);

    scr_l3_bk_tx_state_e r_state;
    scr_l3_bk_tx_state_e w_state_next;

    logic              r_live;
    logic [CW-1:0]     r_crdt;
    logic              r_out_val;
    logic [FLIT_W-1:0] r_out_flit;
    logic              r_idle;

    logic              w_full;
    logic              w_empty;
    logic [FLIT_W-1:0] w_head;
    logic [AW:0]       w_count;
    logic [AW:0]       w_occ_next;
    logic              w_rdy;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_launch;
    logic              w_overflow;
    logic [FLIT_W-1:0] w_src;
    logic [CW-1:0]     w_crdt_next;

    // r_live keeps ready low until the first clock after reset release.
    assign w_rdy    = r_live && !w_full;
    assign w_accept = bus.req_val_i && w_rdy;

    scr_base_l3_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (bus.req_flit_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State tracks the FIFO: IDLE = empty, SEND = head waiting with credit, STALL = head waiting without.
    always_comb begin
        w_launch     = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_src        = w_head;
        w_overflow   = 1'b0;
        w_crdt_next  = r_crdt;
        w_occ_next   = w_count;
        w_state_next = r_state;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (r_crdt != '0) begin
                        w_launch = 1'b1;
                        w_src    = bus.req_flit_i;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            SEND: begin
                w_launch = 1'b1;
                w_pop    = 1'b1;
                w_push   = w_accept;
            end
            STALL: begin
                w_push = w_accept;
            end
            default: begin
                w_push = 1'b0;
            end
        endcase

        w_overflow = bus.req_out_crdt_i && !w_launch && (r_crdt == LP_CRDT_MAX);
        if (!w_overflow) begin
            w_crdt_next = r_crdt + CW'(bus.req_out_crdt_i) - CW'(w_launch);
        end

        w_occ_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        if (w_occ_next == '0) begin
            w_state_next = IDLE;
        end else if (w_crdt_next != '0) begin
            w_state_next = SEND;
        end else begin
            w_state_next = STALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live     <= 1'b0;
            r_state    <= IDLE;
            r_crdt     <= LP_CRDT_MAX;
            r_out_val  <= 1'b0;
            r_out_flit <= '0;
            r_idle     <= 1'b1;
        end else begin
            r_live    <= 1'b1;
            r_state   <= w_state_next;
            r_crdt    <= w_crdt_next;
            r_out_val <= w_launch;
            if (w_launch) begin
                r_out_flit <= w_src;
            end
            r_idle <= (r_state == IDLE) && !r_out_val && (r_crdt == LP_CRDT_MAX);
        end
    end

    assign bus.req_rdy_o      = w_rdy;
    assign bus.req_out_val_o  = r_out_val;
    assign bus.req_out_flit_o = r_out_flit;
    assign bus.crdt_cnt_o     = r_crdt;
    assign bus.idle_o         = r_idle;

`ifdef SCR_L3_BK_REQ_TX_CRDT_CHK_EN
    logic r_crdt_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crdt_err <= 1'b0;
        end else if (w_overflow) begin
            r_crdt_err <= 1'b1;
        end
    end

    assign bus.crdt_err_o = r_crdt_err;

    a_no_crdt_overflow: assert property (@(posedge clk) disable iff (rst) !w_overflow);
    a_val_held_until_rdy: assert property (@(posedge clk) disable iff (rst)
        (bus.req_val_i && !w_rdy) |=> bus.req_val_i);
`else
    assign bus.crdt_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_scr_base_l3_bk_req_tx.sv
// Self-checking bench for scr_base_l3_bk_req_tx: vector table plus scoreboard on the launched flits.
module tb_scr_base_l3_bk_req_tx;
    import scr_base_l3_bk_pkg::*;

`ifdef SCR_L3_BK_REQ_TX_CRDT_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic       val;
        logic [7:0] flit;
        logic       ret;
        logic       eRdy;
        logic       eVal;
        logic [7:0] eFlit;
        logic [3:0] eCrdt;
    } vec_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int passes   = 0;
    int obsCount = 0;

    scr_l3_bk_flit_t sbQ[$];
    vec_t            vecs[14];

    scr_base_l3_bk_req_tx_if bus ();

    scr_base_l3_bk_req_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic scr_l3_bk_flit_t fl(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {16{b}};
    endfunction

    function automatic vec_t mk(input logic val, input logic [7:0] flit, input logic ret,
                                input logic eRdy, input logic eVal, input logic [7:0] eFlit,
                                input logic [3:0] eCrdt);
        vec_t v;
        v.val = val; v.flit = flit; v.ret = ret;
        v.eRdy = eRdy; v.eVal = eVal; v.eFlit = eFlit; v.eCrdt = eCrdt;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic val, input scr_l3_bk_flit_t flit, input logic ret);
        bus.req_val_i      = val;
        bus.req_flit_i     = flit;
        bus.req_out_crdt_i = ret;
    endtask

    task automatic checkOutput(input int k, input vec_t v);
        checkValue($sformatf("vec%0d_rdy", k), 128'(bus.req_rdy_o), 128'(v.eRdy));
        checkValue($sformatf("vec%0d_out_val", k), 128'(bus.req_out_val_o), 128'(v.eVal));
        if (v.eVal) begin
            checkValue($sformatf("vec%0d_out_flit", k), bus.req_out_flit_o, fl(int'(v.eFlit)));
        end
        checkValue($sformatf("vec%0d_crdt", k), 128'(bus.crdt_cnt_o), 128'(v.eCrdt));
    endtask

    task automatic returnCredits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b1);
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    // Scoreboard producer: every accepted flit is expected later on the output, in order.
    always @(posedge clk) begin
        if (!rst && bus.req_val_i && bus.req_rdy_o) begin
            sbQ.push_back(bus.req_flit_i);
        end
    end

    // Scoreboard consumer: every launch must match the oldest outstanding accepted flit.
    always @(posedge clk) begin
        #1;
        if (!rst && bus.req_out_val_o) begin
            obsCount++;
            if (sbQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL sb_unexpected: got flit %0h expected no launch at %0t",
                         bus.req_out_flit_o, $time);
            end else begin
                checkValue("sb_order", bus.req_out_flit_o, sbQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int idx;
        int retGiven;
        logic rdySample;
        logic v;
        logic r;

        vecs[0]  = mk(1, 1, 0, 1, 0, 0, 4);
        vecs[1]  = mk(1, 2, 0, 1, 1, 1, 3);
        vecs[2]  = mk(1, 3, 0, 1, 1, 2, 2);
        vecs[3]  = mk(1, 4, 0, 1, 1, 3, 1);
        vecs[4]  = mk(1, 5, 0, 1, 1, 4, 0);
        vecs[5]  = mk(1, 6, 0, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 1, 1, 5, 0);
        vecs[10] = mk(0, 0, 1, 1, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 1, 6, 0);
        vecs[13] = mk(0, 0, 0, 1, 0, 0, 0);

        applyStimulus(1'b0, '0, 1'b0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #12;
        $display("[TB] reset values");
        checkValue("rst_rdy", 128'(bus.req_rdy_o), 128'(0));
        checkValue("rst_out_val", 128'(bus.req_out_val_o), 128'(0));
        checkValue("rst_out_flit", bus.req_out_flit_o, 128'(0));
        checkValue("rst_crdt", 128'(bus.crdt_cnt_o), 128'(4));
        checkValue("rst_idle", 128'(bus.idle_o), 128'(1));
        checkValue("rst_err", 128'(bus.crdt_err_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] stream 6 flits into 4 credits, then return credits one at a time");
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            checkOutput(k, vecs[k]);
            applyStimulus(vecs[k].val, fl(int'(vecs[k].flit)), vecs[k].ret);
        end

        $display("[TB] steady state: launch and return every cycle at 2 credits");
        returnCredits(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkValue($sformatf("steady%0d_val", i), 128'(bus.req_out_val_o), 128'(1));
                checkValue($sformatf("steady%0d_flit", i), bus.req_out_flit_o, fl(100 + i - 1));
            end
            checkValue($sformatf("steady%0d_crdt", i), 128'(bus.crdt_cnt_o), 128'(2));
            applyStimulus(1'b1, fl(100 + i), 1'b1);
        end
        @(negedge clk);
        checkValue("steady_last_flit", bus.req_out_flit_o, fl(119));
        checkValue("steady_last_crdt", 128'(bus.crdt_cnt_o), 128'(2));
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge clk);
        checkValue("steady_drained_val", 128'(bus.req_out_val_o), 128'(0));

        $display("[TB] credit return while already full");
        returnCredits(2);
        repeat (2) @(negedge clk);
        checkValue("ovf_pre_idle", 128'(bus.idle_o), 128'(1));
        checkValue("ovf_pre_crdt", 128'(bus.crdt_cnt_o), 128'(4));
        checkValue("ovf_pre_err", 128'(bus.crdt_err_o), 128'(0));
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("ovf_crdt", 128'(bus.crdt_cnt_o), 128'(4));
        checkValue("ovf_err", 128'(bus.crdt_err_o), 128'(EXP_ERR));
        repeat (2) @(negedge clk);
        checkValue("ovf_err_sticky", 128'(bus.crdt_err_o), 128'(EXP_ERR));
        checkValue("ovf_crdt_hold", 128'(bus.crdt_cnt_o), 128'(4));

        $display("[TB] reset mid-stream with two buffered flits and one credit");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, fl(200 + i), 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("mid_crdt_one", 128'(bus.crdt_cnt_o), 128'(1));
        checkValue("mid_rdy_full", 128'(bus.req_rdy_o), 128'(0));
        #2 rst = 1'b1;
        sbQ.delete();
        #1;
        checkValue("mid_rst_val", 128'(bus.req_out_val_o), 128'(0));
        checkValue("mid_rst_flit", bus.req_out_flit_o, 128'(0));
        checkValue("mid_rst_crdt", 128'(bus.crdt_cnt_o), 128'(4));
        checkValue("mid_rst_rdy", 128'(bus.req_rdy_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkValue($sformatf("post_rst%0d_val", i), 128'(bus.req_out_val_o), 128'(0));
            checkValue($sformatf("post_rst%0d_idle", i), 128'(bus.idle_o), 128'(1));
        end
        checkValue("post_rst_rdy", 128'(bus.req_rdy_o), 128'(1));

        $display("[TB] FIFO wrap with alternating credit stalls");
        idx = 0;
        retGiven = 0;
        obsCount = 0;
        for (int cyc = 0; cyc < 200 && obsCount < 10; cyc++) begin
            @(negedge clk);
            rdySample = bus.req_rdy_o;
            v = (idx < 10);
            r = ((cyc % 2) == 0) && (retGiven < obsCount);
            applyStimulus(v, fl(300 + idx), r);
            if (r) retGiven++;
            if (v && rdySample) idx++;
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0);
        checkValue("wrap_count", 128'(obsCount), 128'(10));
        checkValue("wrap_sb_empty", 128'(sbQ.size()), 128'(0));
        while (retGiven < obsCount) begin
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b1);
            retGiven++;
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        checkValue("wrap_end_crdt", 128'(bus.crdt_cnt_o), 128'(4));
        checkValue("wrap_end_idle", 128'(bus.idle_o), 128'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
